core_inst_seq: RTL and testbench
================================

Name: core_inst_seq

Overview:
- Instruction sequencer that drives the 34-bit `inst` bus of `core` for one compute tile.
- Flow: weight fetch xmem→L0, weight load into the array, activation fetch xmem→L0, execute, then drain OFIFO into psum SRAM.
- It is the initiator of the `inst` protocol that `core` consumes. It replaces testbench-scripted `inst` streams.

Parameters:
- row, 8, PE rows; number of weight words fetched and loaded per tile.
- col, 8, PE columns; number of idle settle cycles after weight load.
- l0_depth, 64, L0 entries; maximum accepted `len`.
- aw, 11, SRAM address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk rising edge).
- start  in  1  one-cycle start pulse; sampled only in IDLE.
- w_base  in  aw  xmem address of the first weight word.
- x_base  in  aw  xmem address of the first activation word.
- p_base  in  aw  pmem address of the first psum write.
- len  in  aw  number of activation vectors, which equals the number of psum rows.
- acc_en  in  1  value driven onto inst[33] during DRAIN.
- l0_full  in  1  from core.
- ofifo_valid  in  1  from core.
- inst  out  34  instruction bus to core.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse on DONE.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- inst field map:
  - [33] acc
  - [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5:4] reserved (drive 0)
  - [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- CEN and WEN are active-low.
- IDLE_INST = 34'h1_800C_0000: CEN and WEN high, everything else 0.
- inst is a combinational decode of registered state/counters, gated by l0_full and ofifo_valid. No field other than those listed per state is ever asserted.
- Reset: state=IDLE, all counters 0, pend=0, inst=IDLE_INST, busy=0, done=0, err=0. Reset mid-tile aborts immediately; inst=IDLE_INST from the next cycle on.
- IDLE → WFETCH on start when 1 ≤ len ≤ l0_depth; base and len inputs are latched. Otherwise stay in IDLE and pulse err the next cycle.
- Start while busy is ignored.
- Fetch pipe, shared by WFETCH and XFETCH:
  - SRAM read latency is 1 cycle, and Q holds its value while CEN is high.
  - Read issue: CEN_xmem=0, WEN_xmem=1, A_xmem=base+rcnt. Issued when rcnt<N and (pend==0 or l0_full==0). Sets pend; rcnt++.
  - Write to L0: l0_wr = pend & ~l0_full. pend clears on a write unless a new read is issued in the same cycle.
  - With l0_full held, the pipe holds Q and keeps pend set. No read is issued and no word is lost.
  - The phase ends when rcnt==N and pend==0.
- WFETCH: N=row from w_base → WLOAD.
- WLOAD: load=1, l0_rd=1 for row cycles, then col cycles of IDLE_INST (settle) → XFETCH.
- XFETCH: N=len from x_base → EXEC.
- EXEC: execute=1, l0_rd=1 for exactly len cycles → DRAIN.
- DRAIN:
  - On each cycle with ofifo_valid=1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+wcnt, acc=acc_en, and wcnt++ at end of cycle.
  - On cycles with ofifo_valid=0: IDLE_INST with acc=acc_en.
  - Exit when wcnt reaches len → DONE.
- DONE: one cycle, inst=IDLE_INST, done=1 → IDLE.
- Address arithmetic is aw-bit modulo. base+count wraps past 2047 to 0.

Decomposition:
- core_inst_pkg holds:
  - field bit-index localparams
  - IDLE_INST
  - the state encoding (IDLE, WFETCH, WLOAD, WSETTLE, XFETCH, EXEC, DRAIN, DONE)
- Sub-module l0_fill_pipe: read-issue/pend/l0_wr logic with l0_full hold. Instantiated once, with base and N muxed by state.

Test Plan:
- Reset held low 3 cycles mid-EXEC → inst==34'h1_800C_0000, busy=0 on the next cycle; start afterwards runs normally.
- start, w_base=0, x_base=16, len=4, l0_full=0, ofifo_valid=1 →
  - reads at xmem addresses 0..7, each with l0_wr one cycle later
  - load=1 for 8 cycles, then 8 idle cycles
  - reads 16..19, execute=1 for 4 cycles
  - pmem writes at p_base..p_base+3
  - done pulses once
- l0_full=1 for 5 cycles during WFETCH → l0_wr=0 and CEN_xmem=1 throughout; after release, the held word is written and all 8 words are delivered with no duplicates.
- ofifo_valid toggling 1,0,0,1,1,0,1 in DRAIN, len=4 → ofifo_rd and pmem write only on the valid cycles, at addresses p_base+0..3.
- len=0 and len=65 → err pulse, state stays IDLE, inst unchanged.
- p_base=2046, len=4, acc_en=1 → writes at 2046, 2047, 0, 1, with inst[33]=1 in DRAIN.

Source files
------------

// File: rtl/core_inst_seq_pkg.sv
// Shared definitions for the instruction sequencer: inst field positions,
// the idle instruction word and the sequencer state encoding.
package core_inst_pkg;

   localparam int INST_W     = 34;
   localparam int B_ACC      = 33;
   localparam int B_CEN_P    = 32;
   localparam int B_WEN_P    = 31;
   localparam int B_AP_LO    = 20;
   localparam int B_CEN_X    = 19;
   localparam int B_WEN_X    = 18;
   localparam int B_AX_LO    = 7;
   localparam int B_OFIFO_RD = 6;
   localparam int B_L0_RD    = 3;
   localparam int B_L0_WR    = 2;
   localparam int B_EXEC     = 1;
   localparam int B_LOAD     = 0;

   // Both SRAM enables deasserted (active-low), nothing else asserted.
   localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

   typedef enum logic [2:0] {
      S_IDLE, S_WFETCH, S_WLOAD, S_WSETTLE, S_XFETCH, S_EXEC, S_DRAIN, S_DONE
   } state_t;

endpackage

// File: rtl/core_inst_seq_if.sv
// Control/status bundle between a tile controller (master) and the
// instruction sequencer (slave), including the core-side flow-control inputs.
interface core_inst_seq_if #(parameter int aw = 11);
   import core_inst_pkg::*;

   // Handshake: start is a single-cycle request honoured only while busy is
   // low; an out-of-range len answers with a one-cycle err instead of busy.
   // l0_full is backpressure (a word waiting for L0 is held, never dropped)
   // and ofifo_valid qualifies each DRAIN cycle as a pop plus a psum write.
   logic              start;
   logic [aw-1:0]     w_base;
   logic [aw-1:0]     x_base;
   logic [aw-1:0]     p_base;
   logic [aw-1:0]     len;
   logic              acc_en;
   logic              l0_full;
   logic              ofifo_valid;
   logic [INST_W-1:0] inst;
   logic              busy;
   logic              done;
   logic              err;
   state_t            dbg_state;

   modport master (
      output start, w_base, x_base, p_base, len, acc_en, l0_full, ofifo_valid,
      input  inst, busy, done, err, dbg_state
   );

   modport slave (
      input  start, w_base, x_base, p_base, len, acc_en, l0_full, ofifo_valid,
      output inst, busy, done, err, dbg_state
   );

endinterface

// File: rtl/core_inst_seq_l0_fill_pipe.sv
// xmem -> L0 copy pipe: issues N reads from base and forwards each returned
// word to L0 one cycle later, stalling on l0_full with the word held in Q.
module l0_fill_pipe #(
   parameter int aw = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          active,
   input  logic [aw-1:0] base,
   input  logic [aw-1:0] n,
   input  logic          l0_full,
   output logic          rd_issue,
   output logic [aw-1:0] rd_addr,
   output logic          l0_wr,
   output logic          phase_done
);

   logic [aw-1:0] rcnt;
   logic          pend;

   // A new read may only replace the pending word if that word leaves this cycle.
   assign rd_issue   = active && (rcnt < n) && (!pend || !l0_full);
   assign l0_wr      = active && pend && !l0_full;
   assign phase_done = active && (rcnt == n) && !pend;
   assign rd_addr    = base + rcnt;

   always_ff @(posedge clk) begin
      if (!reset || !active) begin
         rcnt <= '0;
         pend <= 1'b0;
      end else if (rd_issue) begin
         rcnt <= rcnt + 1'b1;
         pend <= 1'b1;
      end else if (l0_wr) begin
         pend <= 1'b0;
      end
   end

endmodule

// File: rtl/core_inst_seq.sv
// Per-tile instruction sequencer for core: weight fetch, weight load and
// settle, activation fetch, execute, then drain OFIFO into psum SRAM.
module core_inst_seq
   import core_inst_pkg::*;
#(
   parameter int row      = 8,
   parameter int col      = 8,
   parameter int l0_depth = 64,
   parameter int aw       = 11
) (
   input logic            clk,
   input logic            reset,
   core_inst_seq_if.slave bus
);

   localparam logic [aw-1:0] ROW_N    = aw'(row);
   localparam logic [aw-1:0] ROW_LAST = aw'(row - 1);
   localparam logic [aw-1:0] COL_LAST = aw'(col - 1);
   localparam logic [aw-1:0] LEN_MAX  = aw'(l0_depth);

   state_t            state, state_n;
   logic [aw-1:0]     cnt, wcnt;
   logic [aw-1:0]     w_base_r, x_base_r, p_base_r, len_r;
   logic              err_r, err_n, latch;
   logic              len_ok;
   logic              fetch_active, rd_issue, l0_wr, fetch_done;
   logic [aw-1:0]     fetch_base, fetch_n, rd_addr;
   logic [INST_W-1:0] inst_c;

   assign len_ok       = (bus.len != '0) && (bus.len <= LEN_MAX);
   assign fetch_active = (state == S_WFETCH) || (state == S_XFETCH);
   assign fetch_base   = (state == S_XFETCH) ? x_base_r : w_base_r;
   assign fetch_n      = (state == S_XFETCH) ? len_r : ROW_N;

   l0_fill_pipe #(.aw(aw)) u_fill (
      .clk        (clk),
      .reset      (reset),
      .active     (fetch_active),
      .base       (fetch_base),
      .n          (fetch_n),
      .l0_full    (bus.l0_full),
      .rd_issue   (rd_issue),
      .rd_addr    (rd_addr),
      .l0_wr      (l0_wr),
      .phase_done (fetch_done)
   );

   always_comb begin
      state_n = state;
      inst_c  = IDLE_INST;
      latch   = 1'b0;
      err_n   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (len_ok) begin
                  state_n = S_WFETCH;
                  latch   = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         S_WFETCH, S_XFETCH: begin
            inst_c[B_CEN_X] = ~rd_issue;
            if (rd_issue) inst_c[B_AX_LO +: aw] = rd_addr;
            inst_c[B_L0_WR] = l0_wr;
            if (fetch_done) state_n = (state == S_WFETCH) ? S_WLOAD : S_EXEC;
         end
         S_WLOAD: begin
            inst_c[B_LOAD]  = 1'b1;
            inst_c[B_L0_RD] = 1'b1;
            if (cnt == ROW_LAST) state_n = S_WSETTLE;
         end
         S_WSETTLE: begin
            if (cnt == COL_LAST) state_n = S_XFETCH;
         end
         S_EXEC: begin
            inst_c[B_EXEC]  = 1'b1;
            inst_c[B_L0_RD] = 1'b1;
            if (cnt == len_r - 1'b1) state_n = S_DRAIN;
         end
         S_DRAIN: begin
            inst_c[B_ACC] = bus.acc_en;
            if (bus.ofifo_valid) begin
               inst_c[B_OFIFO_RD]      = 1'b1;
               inst_c[B_CEN_P]         = 1'b0;
               inst_c[B_WEN_P]         = 1'b0;
               inst_c[B_AP_LO +: aw]   = p_base_r + wcnt;
               if (wcnt == len_r - 1'b1) state_n = S_DONE;
            end
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         wcnt     <= '0;
         err_r    <= 1'b0;
         w_base_r <= '0;
         x_base_r <= '0;
         p_base_r <= '0;
         len_r    <= '0;
      end else begin
         state <= state_n;
         err_r <= err_n;
         if (latch) begin
            w_base_r <= bus.w_base;
            x_base_r <= bus.x_base;
            p_base_r <= bus.p_base;
            len_r    <= bus.len;
         end
         // cnt measures cycles spent in the current state.
         cnt <= (state_n != state) ? '0 : cnt + 1'b1;
         if (state != S_DRAIN)       wcnt <= '0;
         else if (bus.ofifo_valid)   wcnt <= wcnt + 1'b1;
      end
   end

   assign bus.inst      = inst_c;
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.err       = err_r;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_core_inst_seq.sv
// Self-checking bench for core_inst_seq: a phase-level model predicts inst,
// busy, done and err every cycle; directed tiles pin the model with literals.
module tb_core_inst_seq;

   localparam int AW = 11;
   localparam logic [33:0] IDLE_I = 34'h1_800C_0000;
   localparam int P_IDLE = 0, P_WF = 1, P_WL = 2, P_WS = 3, P_XF = 4, P_EX = 5, P_DR = 6, P_DN = 7;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   core_inst_seq_if #(.aw(AW)) bus();

   core_inst_seq #(.row(8), .col(8), .l0_depth(64), .aw(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // model state
   int         ph = P_IDLE;
   int         rcnt = 0, spent = 0, wcnt = 0;
   int         m_wb = 0, m_xb = 0, m_pb = 0, m_len = 0;
   bit         m_err = 1'b0;
   logic [10:0] held_q[$];

   // observation logs, cleared per tile
   int rd_log[$];
   int pm_log[$];
   int wr_cnt, load_cnt, exec_cnt, done_cnt, err_cnt, busy_cnt, acc_cnt, ofifo_cnt;

   // stimulus controls
   int full_pct = 0, valid_pct = 100;
   bit hold_mode = 1'b0, vpat_mode = 1'b0;
   int wf_cyc = 0, vidx = 0;
   bit vpat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_q(input string nm, input int got[$], input int exp[$]);
      bit bad;
      bad = (got.size() != exp.size());
      if (!bad) for (int i = 0; i < exp.size(); i++) if (got[i] != exp[i]) bad = 1'b1;
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL %s: got %0d entries (first %0d) expected %0d entries (first %0d)",
                  nm, got.size(), (got.size() > 0) ? got[0] : -1,
                  exp.size(), (exp.size() > 0) ? exp[0] : -1);
      end
   endtask

   // Compare against the model, log DUT events, then advance the model.
   always @(negedge clk) begin : cmp
      logic [33:0] e;
      bit          issue, wr;
      int          n, base;
      logic [10:0] a;
      e = IDLE_I; issue = 1'b0; wr = 1'b0; n = 0; base = 0; a = '0;
      case (ph)
         P_WF, P_XF: begin
            n     = (ph == P_WF) ? 8 : m_len;
            base  = (ph == P_WF) ? m_wb : m_xb;
            issue = (rcnt < n) && (held_q.size() == 0 || !bus.l0_full);
            wr    = (held_q.size() != 0) && !bus.l0_full;
            if (issue) begin
               a = 11'(base + rcnt);
               e[19] = 1'b0;
               e[17:7] = a;
            end
            e[2] = wr;
         end
         P_WL: begin e[0] = 1'b1; e[3] = 1'b1; end
         P_EX: begin e[1] = 1'b1; e[3] = 1'b1; end
         P_DR: begin
            e[33] = bus.acc_en;
            if (bus.ofifo_valid) begin
               e[32] = 1'b0; e[31] = 1'b0;
               e[30:20] = 11'(m_pb + wcnt);
               e[6] = 1'b1;
            end
         end
         default: ;
      endcase
      chk("inst", bus.inst, e);
      chk("busy", 34'(bus.busy), 34'(ph != P_IDLE));
      chk("done", 34'(bus.done), 34'(ph == P_DN));
      chk("err",  34'(bus.err),  34'(m_err));

      if (!bus.inst[19]) rd_log.push_back(int'(bus.inst[17:7]));
      if (!bus.inst[32]) pm_log.push_back(int'(bus.inst[30:20]));
      if (bus.inst[2])  wr_cnt++;
      if (bus.inst[0])  load_cnt++;
      if (bus.inst[1])  exec_cnt++;
      if (bus.inst[33]) acc_cnt++;
      if (bus.inst[6])  ofifo_cnt++;
      if (bus.done)     done_cnt++;
      if (bus.err)      err_cnt++;
      if (bus.busy)     busy_cnt++;

      if (!reset) begin
         ph = P_IDLE; rcnt = 0; spent = 0; wcnt = 0; m_err = 1'b0;
         held_q.delete();
      end else begin
         m_err = 1'b0;
         case (ph)
            P_IDLE: if (bus.start) begin
               if (bus.len >= 1 && bus.len <= 64) begin
                  m_wb = int'(bus.w_base); m_xb = int'(bus.x_base);
                  m_pb = int'(bus.p_base); m_len = int'(bus.len);
                  ph = P_WF; rcnt = 0; held_q.delete();
               end else m_err = 1'b1;
            end
            P_WF, P_XF: begin
               if (rcnt == n && held_q.size() == 0) begin
                  ph = (ph == P_WF) ? P_WL : P_EX;
                  spent = 0; rcnt = 0;
               end else begin
                  if (wr) void'(held_q.pop_front());
                  if (issue) begin held_q.push_back(a); rcnt++; end
               end
            end
            P_WL: begin spent++; if (spent == 8) begin ph = P_WS; spent = 0; end end
            P_WS: begin spent++; if (spent == 8) begin ph = P_XF; spent = 0; rcnt = 0; end end
            P_EX: begin spent++; if (spent == m_len) begin ph = P_DR; wcnt = 0; end end
            P_DR: if (bus.ofifo_valid) begin wcnt++; if (wcnt == m_len) ph = P_DN; end
            P_DN: ph = P_IDLE;
            default: ph = P_IDLE;
         endcase
      end
   end

   task automatic clear_logs();
      rd_log.delete(); pm_log.delete();
      wr_cnt = 0; load_cnt = 0; exec_cnt = 0; done_cnt = 0;
      err_cnt = 0; busy_cnt = 0; acc_cnt = 0; ofifo_cnt = 0;
      wf_cyc = 0; vidx = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (hold_mode) bus.l0_full = (ph == P_WF) && (wf_cyc >= 3) && (wf_cyc < 8);
      else           bus.l0_full = (int'($urandom_range(0, 99)) < full_pct);
      if (ph == P_WF) wf_cyc++;
      if (vpat_mode && ph == P_DR) begin
         bus.ofifo_valid = (vidx < 7) ? vpat[vidx] : 1'b1;
         vidx++;
      end else begin
         bus.ofifo_valid = (int'($urandom_range(0, 99)) < valid_pct);
      end
   endtask

   task automatic set_tile(input int wb, input int xb, input int pb, input int ln, input bit acc);
      bus.w_base = 11'(wb); bus.x_base = 11'(xb); bus.p_base = 11'(pb);
      bus.len = 11'(ln); bus.acc_en = acc;
   endtask

   task automatic run_tile(input int wb, input int xb, input int pb, input int ln, input bit acc);
      int k;
      clear_logs();
      set_tile(wb, xb, pb, ln, acc);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      k = 0;
      step();
      while (ph != P_IDLE && k < 3000) begin
         // a start while busy must be ignored
         bus.start = (k == 4);
         step();
         k++;
      end
      bus.start = 1'b0;
      chk("tile_timeout", 34'(k < 3000), 34'(1));
   endtask

   initial begin
      int exp_q[$];
      int k, ln;
      bus.start = 1'b0; bus.l0_full = 1'b0; bus.ofifo_valid = 1'b0;
      set_tile(0, 0, 0, 1, 1'b0);

      // reset state
      repeat (3) step();
      reset = 1'b1;
      step();
      chk("rst_inst", bus.inst, IDLE_I);
      chk("rst_busy", 34'(bus.busy), 34'(0));
      chk("rst_done", 34'(bus.done), 34'(0));
      chk("rst_err",  34'(bus.err),  34'(0));

      // basic tile
      run_tile(0, 16, 100, 4, 1'b0);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(i);
      for (int i = 0; i < 4; i++) exp_q.push_back(16 + i);
      chk_q("basic_reads", rd_log, exp_q);
      chk("basic_wr_cnt",   34'(wr_cnt),   34'(12));
      chk("basic_load_cnt", 34'(load_cnt), 34'(8));
      chk("basic_exec_cnt", 34'(exec_cnt), 34'(4));
      chk("basic_done_cnt", 34'(done_cnt), 34'(1));
      chk("basic_busy_len", 34'(busy_cnt), 34'(41));
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(100 + i);
      chk_q("basic_pmem", pm_log, exp_q);

      // l0_full held 5 cycles in WFETCH
      hold_mode = 1'b1;
      run_tile(0, 16, 200, 4, 1'b0);
      hold_mode = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(i);
      for (int i = 0; i < 4; i++) exp_q.push_back(16 + i);
      chk_q("hold_reads", rd_log, exp_q);
      chk("hold_wr_cnt",   34'(wr_cnt),   34'(12));
      chk("hold_busy_len", 34'(busy_cnt), 34'(46));

      // ofifo_valid pattern in DRAIN
      vpat_mode = 1'b1;
      run_tile(0, 16, 300, 4, 1'b0);
      vpat_mode = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(300 + i);
      chk_q("vpat_pmem", pm_log, exp_q);
      chk("vpat_ofifo_cnt", 34'(ofifo_cnt), 34'(4));
      chk("vpat_busy_len",  34'(busy_cnt),  34'(44));

      // rejected lengths
      foreach (exp_q[i]) exp_q[i] = 0;
      for (int t = 0; t < 2; t++) begin
         clear_logs();
         set_tile(5, 6, 7, (t == 0) ? 0 : 65, 1'b0);
         bus.start = 1'b1;
         step();
         bus.start = 1'b0;
         repeat (3) step();
         chk((t == 0) ? "len0_err" : "len65_err", 34'(err_cnt), 34'(1));
         chk((t == 0) ? "len0_busy" : "len65_busy", 34'(busy_cnt), 34'(0));
         chk((t == 0) ? "len0_reads" : "len65_reads", 34'(rd_log.size()), 34'(0));
      end

      // address wrap with accumulate
      run_tile(2040, 2045, 2046, 4, 1'b1);
      exp_q = '{2046, 2047, 0, 1};
      chk_q("wrap_pmem", pm_log, exp_q);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(2040 + i);
      exp_q.push_back(2045); exp_q.push_back(2046); exp_q.push_back(2047); exp_q.push_back(0);
      chk_q("wrap_reads", rd_log, exp_q);
      chk("wrap_acc_cnt", 34'(acc_cnt), 34'(4));

      // reset in the middle of EXEC
      clear_logs();
      set_tile(0, 16, 400, 6, 1'b0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      k = 0;
      while (ph != P_EX && k < 500) begin step(); k++; end
      chk("exec_reached", 34'(k < 500), 34'(1));
      step();
      reset = 1'b0;
      step();
      chk("abort_inst", bus.inst, IDLE_I);
      chk("abort_busy", 34'(bus.busy), 34'(0));
      repeat (2) step();
      reset = 1'b1;
      step();
      run_tile(0, 16, 400, 6, 1'b0);
      chk("after_abort_done", 34'(done_cnt), 34'(1));
      chk("after_abort_pmem", 34'(pm_log.size()), 34'(6));

      // boundary lengths and randomized tiles with random backpressure
      for (int t = 0; t < 12; t++) begin
         ln = (t == 0) ? 64 : (t == 1) ? 1 : int'($urandom_range(1, 64));
         full_pct  = int'($urandom_range(0, 50));
         valid_pct = int'($urandom_range(30, 100));
         run_tile(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                  int'($urandom_range(0, 2047)), ln, 1'($urandom_range(0, 1)));
         chk("rand_done_cnt", 34'(done_cnt), 34'(1));
         chk("rand_pmem_cnt", 34'(pm_log.size()), 34'(ln));
         chk("rand_wr_cnt",   34'(wr_cnt), 34'(8 + ln));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
